// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc : multi-cycle execute-stage ALU with registered result and N/Z/V/C
//          status register, shifts, and an optional iterative unsigned
//          multiplier.
//
// Configuration macro: ALU_MUL_EN
//   defined   -> opcode 0011 (MULU) runs a shift-add multiplier, one bit of b
//                per clock (latency WIDTH+1, busy for WIDTH cycles).
//   undefined -> multiplier, MUL state and counter are absent; 0011 is an
//                illegal opcode, busy is tied 0 and sum_hi is always 0.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           request, sampled only while idle
//   gin[3:0]        opcode
//   a, b            operands, captured with start
//   sum, sum_hi     registered result (sum_hi = MUL high word, else 0)
//   busy            multi-cycle op in progress
//   done            one-cycle pulse, result and flags valid from this cycle
//   zout            sum == 0, registered with sum
//   nORv            pass-if-nonpositive taken flag (opcode 1111 only)
//   illegal         one-cycle pulse with done for an undefined opcode
//   statusN/Z/V/C   status register, updated on done of legal ops
//
// Handshake: the requester holds start/gin/a/b for one clock while the block
// is idle (busy == 0). The block answers with exactly one done pulse per
// accepted request; start seen while busy is dropped, and start seen in a
// done cycle is accepted, so single-cycle ops can issue every clock.
// -----------------------------------------------------------------------------
module alu_mc #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       gin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] sum_hi,
  output logic             busy,
  output logic             done,
  output logic             zout,
  output logic             nORv,
  output logic             illegal,
  output logic             statusN,
  output logic             statusZ,
  output logic             statusV,
  output logic             statusC
);

  // ---------------------------------------------------------------------------
  // Single-cycle operation datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] op_res;
  logic             op_c, op_v, op_norv, op_legal, op_is_mul;
  logic [WIDTH:0]   add_full, sub_full;
  logic [SHW-1:0]   sh_amt;

  always_comb begin
    op_res    = '0;
    op_c      = 1'b0;
    op_v      = 1'b0;
    op_norv   = 1'b0;
    op_legal  = 1'b1;
    op_is_mul = 1'b0;
    sh_amt    = b[SHW-1:0];
    add_full  = {1'b0, a} + {1'b0, b};
    // Subtract as a + ~b + 1 so the carry-out reads as "no borrow".
    sub_full  = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    case (gin)
      4'b0010: begin
        op_res = add_full[WIDTH-1:0];
        op_c   = add_full[WIDTH];
        op_v   = (a[WIDTH-1] == b[WIDTH-1]) && (op_res[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0110: begin
        op_res = sub_full[WIDTH-1:0];
        op_c   = sub_full[WIDTH];
        op_v   = (a[WIDTH-1] != b[WIDTH-1]) && (op_res[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0111: op_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b0000: op_res = a & b;
      4'b0001: op_res = a | b;
      4'b1010: op_res = ~(a | b);
      4'b1001: op_res = a ^ b;
      4'b1000: op_res = a;
      4'b1111: begin
        // Non-positive a passes through and raises nORv; positive a yields 1.
        if (a[WIDTH-1] || (a == '0)) begin
          op_res  = a;
          op_norv = 1'b1;
        end else begin
          op_res  = {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end
      4'b0100: op_res = a << sh_amt;
      4'b0101: op_res = a >> sh_amt;
      4'b1011: op_res = $signed(a) >>> sh_amt;
`ifdef ALU_MUL_EN
      4'b0011: op_is_mul = 1'b1;
`endif
      default: op_legal = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers common to both builds
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             zout_q, zout_d;
  logic             norv_q, norv_d;
  logic             illegal_q, illegal_d;
  logic             n_q, n_d, z_q, z_d, v_q, v_d, c_q, c_d;

`ifdef ALU_MUL_EN
  // ---------------------------------------------------------------------------
  // Iterative multiplier: prod holds {partial product, remaining multiplier
  // bits}. Each step adds the multiplicand to the upper half when the current
  // multiplier LSB is set, then shifts the whole register right by one.
  // ---------------------------------------------------------------------------
  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   sum_hi_q, sum_hi_d;
  logic [WIDTH:0]     mul_part;
  logic [2*WIDTH-1:0] mul_step;

  always_comb begin
    mul_part = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    mul_step = {mul_part, prod_q[WIDTH-1:1]};
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    sum_d     = sum_q;
    zout_d    = zout_q;
    norv_d    = norv_q;
    n_d       = n_q;
    z_d       = z_q;
    v_d       = v_q;
    c_d       = c_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    illegal_d = 1'b0;
`ifdef ALU_MUL_EN
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    sum_hi_d  = sum_hi_q;
    case (state_q)
      IDLE: begin
        if (start && op_is_mul) begin
          state_d = MUL;
          cnt_d   = SHW'(WIDTH-1);
          mcand_d = a;
          prod_d  = {{WIDTH{1'b0}}, b};
          busy_d  = 1'b1;
        end else if (start) begin
          done_d    = 1'b1;
          sum_d     = op_res;
          sum_hi_d  = '0;
          zout_d    = (op_res == '0);
          norv_d    = op_norv;
          illegal_d = ~op_legal;
          if (op_legal) begin
            n_d = op_res[WIDTH-1];
            z_d = (op_res == '0);
            v_d = op_v;
            c_d = op_c;
          end
        end
      end
      MUL: begin
        prod_d = mul_step;
        if (cnt_q == '0) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          sum_d    = mul_step[WIDTH-1:0];
          sum_hi_d = mul_step[2*WIDTH-1:WIDTH];
          zout_d   = (mul_step[WIDTH-1:0] == '0);
          norv_d   = 1'b0;
          n_d      = mul_step[WIDTH-1];
          z_d      = (mul_step[WIDTH-1:0] == '0);
          v_d      = (mul_step[2*WIDTH-1:WIDTH] != '0);
          c_d      = 1'b0;
        end else begin
          cnt_d  = cnt_q - SHW'(1);
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
`else
    if (start) begin
      done_d    = 1'b1;
      sum_d     = op_res;
      zout_d    = (op_res == '0);
      norv_d    = op_norv;
      illegal_d = ~op_legal;
      if (op_legal) begin
        n_d = op_res[WIDTH-1];
        z_d = (op_res == '0);
        v_d = op_v;
        c_d = op_c;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      zout_q    <= 1'b0;
      norv_q    <= 1'b0;
      illegal_q <= 1'b0;
      n_q       <= 1'b0;
      z_q       <= 1'b0;
      v_q       <= 1'b0;
      c_q       <= 1'b0;
`ifdef ALU_MUL_EN
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      prod_q    <= '0;
      sum_hi_q  <= '0;
`endif
    end else begin
      sum_q     <= sum_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      zout_q    <= zout_d;
      norv_q    <= norv_d;
      illegal_q <= illegal_d;
      n_q       <= n_d;
      z_q       <= z_d;
      v_q       <= v_d;
      c_q       <= c_d;
`ifdef ALU_MUL_EN
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      prod_q    <= prod_d;
      sum_hi_q  <= sum_hi_d;
`endif
    end
  end

  assign sum     = sum_q;
  assign done    = done_q;
  assign zout    = zout_q;
  assign nORv    = norv_q;
  assign illegal = illegal_q;
  assign statusN = n_q;
  assign statusZ = z_q;
  assign statusV = v_q;
  assign statusC = c_q;
`ifdef ALU_MUL_EN
  assign busy    = busy_q;
  assign sum_hi  = sum_hi_q;
`else
  assign busy    = 1'b0;
  assign sum_hi  = '0;
`endif

endmodule

// File: tb/tb_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_mc : self-checking bench for alu_mc (WIDTH = 32). Directed vectors
// followed by randomized operations, all compared against a behavioural
// model that computes results from plain wide arithmetic.
// -----------------------------------------------------------------------------
module tb_alu_mc;

  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   gin = '0;
  logic [W-1:0] a = '0, b = '0;
  logic [W-1:0] sum, sum_hi;
  logic         busy, done, zout, nORv, illegal;
  logic         statusN, statusZ, statusV, statusC;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gin(gin), .a(a), .b(b),
    .sum(sum), .sum_hi(sum_hi), .busy(busy), .done(done), .zout(zout),
    .nORv(nORv), .illegal(illegal), .statusN(statusN), .statusZ(statusZ),
    .statusV(statusV), .statusC(statusC)
  );

  int checks = 0;
  int failures = 0;
  logic [3:0] cur_op = '0;

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_sum, exp_hi;
  logic         exp_norv, exp_ill;
  int           exp_lat;
  logic         fn = 0, fz = 0, fv = 0, fc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s op=%h observed=%0h expected=%0h", tag, cur_op, obs, exp);
    end
  endtask

  function automatic void model_op(input logic [3:0] g, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, t;
    logic [63:0] wide;
    logic [W-1:0] r;
    int sh;
    bit upd;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = int'(y % W);
    r = '0; exp_hi = '0; exp_norv = 0; exp_ill = 0; exp_lat = 1; upd = 1;
    case (g)
      4'h2: begin
        wide = {32'b0, x} + {32'b0, y}; r = wide[31:0];
        t = sx + sy; fv = (t > SMAX) || (t < SMIN); fc = wide[32];
      end
      4'h6: begin
        r = x - y;
        t = sx - sy; fv = (t > SMAX) || (t < SMIN); fc = (x >= y);
      end
      4'h7: begin r = (sx < sy) ? 1 : 0; fv = 0; fc = 0; end
      4'h0: begin r = x & y; fv = 0; fc = 0; end
      4'h1: begin r = x | y; fv = 0; fc = 0; end
      4'hA: begin r = ~(x | y); fv = 0; fc = 0; end
      4'h9: begin r = x ^ y; fv = 0; fc = 0; end
      4'h8: begin r = x; fv = 0; fc = 0; end
      4'hF: begin
        if (sx <= 0) begin r = x; exp_norv = 1; end else r = 1;
        fv = 0; fc = 0;
      end
      4'h4: begin r = x << sh; fv = 0; fc = 0; end
      4'h5: begin r = x >> sh; fv = 0; fc = 0; end
      4'hB: begin wide = sx >>> sh; r = wide[31:0]; fv = 0; fc = 0; end
`ifdef ALU_MUL_EN
      4'h3: begin
        wide = {32'b0, x} * {32'b0, y};
        r = wide[31:0]; exp_hi = wide[63:32]; exp_lat = W + 1;
        fv = (exp_hi != 0); fc = 0;
      end
`endif
      default: begin r = '0; exp_ill = 1; upd = 0; end
    endcase
    exp_sum = r;
    if (upd) begin
      fn = r[W-1];
      fz = (r == 0);
    end
  endfunction

  task automatic check_outputs();
    chk("sum", sum, exp_sum);
    chk("sum_hi", sum_hi, exp_hi);
    chk("zout", zout, exp_sum == 0);
    chk("nORv", nORv, exp_norv);
    chk("illegal", illegal, exp_ill);
    chk("busy_at_done", busy, 0);
    chk("statusN", statusN, fn);
    chk("statusZ", statusZ, fz);
    chk("statusV", statusV, fv);
    chk("statusC", statusC, fc);
  endtask

  task automatic check_reset_vals();
    chk("rst_sum", sum, 0);
    chk("rst_sum_hi", sum_hi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_zout", zout, 0);
    chk("rst_nORv", nORv, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_N", statusN, 0);
    chk("rst_Z", statusZ, 0);
    chk("rst_V", statusV, 0);
    chk("rst_C", statusC, 0);
  endtask

  // Issue one op, wait (bounded) for done, check latency, busy span, results,
  // and that done is a single-cycle pulse. poke drives a stray start while busy.
  task automatic run_op(input logic [3:0] g, input logic [W-1:0] x, input logic [W-1:0] y, input bit poke);
    int cyc, busy_n;
    cur_op = g;
    model_op(g, x, y);
    @(negedge clk);
    start = 1; gin = g; a = x; b = y;
    @(negedge clk);
    start = 0; gin = 4'($urandom); a = $urandom; b = $urandom;
    cyc = 1; busy_n = 0;
    while (done !== 1'b1 && cyc < 60) begin
      if (busy === 1'b1) busy_n++;
      start = (poke && cyc == 5);
      @(negedge clk);
      cyc++;
    end
    start = 0;
    chk("latency", cyc, exp_lat);
    chk("busy_cycles", busy_n, exp_lat - 1);
    check_outputs();
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Directed + random sequence
  // ---------------------------------------------------------------------------
  initial begin
    int dn;
    a = $urandom; b = $urandom; gin = 4'($urandom);
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst_n = 1;

    // ADD overflow into the sign bit
    run_op(4'h2, 32'h7FFF_FFFF, 32'h1, 0);
    chk("add_sum_const", sum, 32'h8000_0000);
    chk("add_flags_const", {statusN, statusV, statusC, statusZ}, 4'b1100);

    // SUB then SLT back-to-back
    @(negedge clk);
    cur_op = 4'h6; model_op(4'h6, 32'd5, 32'd5);
    start = 1; gin = 4'h6; a = 32'd5; b = 32'd5;
    @(negedge clk);
    chk("b2b_done1", done, 1);
    check_outputs();
    chk("sub_zc_const", {sum == 0, statusZ, statusC}, 3'b111);
    cur_op = 4'h7; model_op(4'h7, 32'hFFFF_FFFF, 32'h1);
    gin = 4'h7; a = 32'hFFFF_FFFF; b = 32'h1;
    @(negedge clk);
    start = 0;
    chk("b2b_done2", done, 1);
    check_outputs();
    chk("slt_const", sum, 32'h1);
    @(negedge clk);
    chk("b2b_done_end", done, 0);

    // MULU with a stray start while busy
    run_op(4'h3, 32'hFFFF_FFFF, 32'h2, 1);

    // pass-if-nonpositive
    run_op(4'hF, 32'h0, $urandom, 0);
    chk("p1111_zero_const", {sum, nORv}, {32'h0, 1'b1});
    run_op(4'hF, 32'd5, $urandom, 0);
    chk("p1111_pos_const", {sum, nORv}, {32'h1, 1'b0});

    // shifts
    run_op(4'hB, 32'h8000_0000, 32'd4, 0);
    chk("sra_const", sum, 32'hF800_0000);
    run_op(4'h4, 32'h1, 32'h21, 0);
    chk("sll_wrap_const", sum, 32'h2);

    // illegal opcode leaves flags alone
    run_op(4'hC, $urandom, $urandom, 0);

    // randomized operations
    for (int i = 0; i < 60; i++) begin
      run_op(4'($urandom_range(0, 15)), pick(), pick(), 0);
    end

    // reset in the middle of a multiply
    cur_op = 4'h3;
    @(negedge clk);
    start = 1; gin = 4'h3; a = 32'hFFFF_FFFF; b = 32'h2;
    @(negedge clk);
    start = 0; dn = 0;
    repeat (9) begin
      if (done === 1'b1) dn++;
      @(negedge clk);
    end
    rst_n = 0;
    #1;
    check_reset_vals();
`ifdef ALU_MUL_EN
    chk("mid_mul_no_done", dn, 0);
`else
    chk("mid_mul_no_done", dn, 1);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1;
    fn = 0; fz = 0; fv = 0; fc = 0;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    chk("post_reset_no_done", dn, 0);
    run_op(4'h2, 32'd100, 32'd23, 0);
    chk("post_reset_add_const", sum, 32'd123);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
